// File: rtl/cpu_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// classes, and the opcode/opext/condition field values.
package cpu_controller_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM
    } state_t;

    typedef enum logic [2:0] {
        OC_NOP,
        OC_ALU,
        OC_BRANCH,
        OC_LOAD,
        OC_STOR
    } opclass_t;

    localparam logic [3:0] OP_REG   = 4'h0;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_BCOND = 4'hC;

    localparam logic [3:0] EXT_AND  = 4'h1;
    localparam logic [3:0] EXT_OR   = 4'h2;
    localparam logic [3:0] EXT_XOR  = 4'h3;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;
    localparam logic [3:0] EXT_MOV  = 4'hD;
    localparam logic [3:0] EXT_LOAD = 4'h0;
    localparam logic [3:0] EXT_STOR = 4'h4;

    localparam logic [3:0] COND_EQ  = 4'h0;
    localparam logic [3:0] COND_NE  = 4'h1;
    localparam logic [3:0] COND_LT  = 4'hC;
    localparam logic [3:0] COND_AL  = 4'hE;

    // Immediate ALU ops reuse the opext value as their opcode.
    function automatic logic is_alu_code(input logic [3:0] code);
        return (code == EXT_AND) || (code == EXT_OR)  || (code == EXT_XOR) ||
               (code == EXT_ADD) || (code == EXT_SUB) || (code == EXT_CMP) ||
               (code == EXT_MOV);
    endfunction

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// Purely combinational decode of the latched instruction register into an
// op class, ALU opcode and the per-instruction enables.
module instr_decoder
    import cpu_controller_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_ir,
    input  logic [2:0]       i_flags,
    output opclass_t         o_class,
    output logic [7:0]       o_alu_op,
    output logic             o_imm_sel,
    output logic             o_wr_en,
    output logic             o_flag_en,
    output logic             o_br_taken
);

    logic [3:0] w_op;
    logic [3:0] w_ext;
    logic [3:0] w_cond;
    logic       w_z;
    logic       w_n;

    assign w_op     = i_ir[15:12];
    assign w_ext    = i_ir[7:4];
    assign w_cond   = i_ir[11:8];
    assign w_z      = i_flags[0];
    assign w_n      = i_flags[1];
    assign o_alu_op = {i_ir[15:12], i_ir[7:4]};

    always_comb begin
        o_class    = OC_NOP;
        o_imm_sel  = 1'b0;
        o_wr_en    = 1'b0;
        o_flag_en  = 1'b0;
        o_br_taken = 1'b0;
        if (w_op == OP_REG && is_alu_code(w_ext)) begin
            o_class   = OC_ALU;
            o_wr_en   = (w_ext != EXT_CMP);
            o_flag_en = (w_ext != EXT_MOV);
        end else if (w_op != OP_REG && is_alu_code(w_op)) begin
            o_class   = OC_ALU;
            o_imm_sel = 1'b1;
            o_wr_en   = (w_op != EXT_CMP);
            o_flag_en = (w_op != EXT_MOV);
        end else if (w_op == OP_MEM) begin
            if (w_ext == EXT_LOAD)
                o_class = OC_LOAD;
            else if (w_ext == EXT_STOR)
                o_class = OC_STOR;
        end else if (w_op == OP_BCOND) begin
            o_class = OC_BRANCH;
            case (w_cond)
                COND_EQ: o_br_taken = w_z;
                COND_NE: o_br_taken = ~w_z;
                COND_LT: o_br_taken = w_n;
                COND_AL: o_br_taken = 1'b1;
                default: o_br_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle control FSM: fetches over a req/ready handshake, decodes the IR
// and sequences regfile, ALU, flag, load/store and PC strobes.
module cpu_controller
    import cpu_controller_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   instr,
    input  logic               mem_ready,
    input  logic [2:0]         flags,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               ir_load,
    output logic               pc_en,
    output logic               pc_src,
    output logic [REGBITS-1:0] src_addr,
    output logic [REGBITS-1:0] dest_addr,
    output logic [7:0]         alu_op,
    output logic               imm_sel,
    output logic               wb_sel,
    output logic               reg_write,
    output logic               flag_write
);

    state_t           r_state;
    logic [WIDTH-1:0] r_ir;
    opclass_t         w_class;
    logic             w_wr_en;
    logic             w_flag_en;
    logic             w_br_taken;
    logic             w_run;

    instr_decoder #(.WIDTH(WIDTH)) u_dec (
        .i_ir       (r_ir),
        .i_flags    (flags),
        .o_class    (w_class),
        .o_alu_op   (alu_op),
        .o_imm_sel  (imm_sel),
        .o_wr_en    (w_wr_en),
        .o_flag_en  (w_flag_en),
        .o_br_taken (w_br_taken)
    );

    assign src_addr  = r_ir[REGBITS-1:0];
    assign dest_addr = r_ir[8 +: REGBITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RESET;
            r_ir    <= '0;
        end else begin
            case (r_state)
                ST_RESET:  r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= instr;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: r_state <= (w_class == OC_LOAD || w_class == OC_STOR) ? ST_MEM : ST_EXEC;
                ST_EXEC:   r_state <= ST_FETCH;
                ST_MEM:    if (mem_ready) r_state <= ST_FETCH;
                default:   r_state <= ST_RESET;
            endcase
        end
    end

    // Completion strobes are masked by reset so an aborted transaction never
    // commits a write or a PC update in the cycle reset arrives.
    assign w_run = ~reset;

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        pc_src       = 1'b0;
        wb_sel       = 1'b0;
        reg_write    = 1'b0;
        flag_write   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready & w_run;
            end
            ST_EXEC: begin
                pc_en      = w_run;
                reg_write  = w_run & (w_class == OC_ALU) & w_wr_en;
                flag_write = w_run & (w_class == OC_ALU) & w_flag_en;
                pc_src     = (w_class == OC_BRANCH) & w_br_taken;
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (w_class == OC_STOR);
                if (mem_ready && w_run) begin
                    pc_en = 1'b1;
                    if (w_class == OC_LOAD) begin
                        wb_sel    = 1'b1;
                        reg_write = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
